// File: rtl/uart_frame_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
package uart_sched_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/uart_frame_sched_if.sv
// Frame-source request bus plus byte-stream handshake toward the UART tx core.
interface uart_frame_sched_if
  import uart_sched_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int FRAME_BYTES = 6
);

  logic [N_SRC-1:0]                    req;
  logic [N_SRC*FRAME_BYTES*BYTE_W-1:0] req_data;
  logic [N_SRC-1:0]                    grant;
  logic [N_SRC-1:0]                    done;
  logic                                busy;
  logic [BYTE_W-1:0]                   tx_data;
  logic                                tx_valid;
  logic                                tx_ready;

  modport master (
    output req, req_data, tx_ready,
    input  grant, done, busy, tx_data, tx_valid
  );

  modport slave (
    input  req, req_data, tx_ready,
    output grant, done, busy, tx_data, tx_valid
  );

endinterface

// File: rtl/uart_frame_sched_rr_arbiter.sv
// Combinational round-robin picker: lowest set request at or above ptr, else lowest overall.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic [N-1:0] upper;
  logic [N-1:0] cand;

  always_comb begin
    upper = '0;
    for (int i = 0; i < N; i++) begin
      upper[i] = req[i] && (IW'(i) >= ptr);
    end
    cand  = (|upper) ? upper : req;
    grant = '0;
    index = '0;
    // descending scan so the lowest candidate is the one left standing
    for (int i = N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        index    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/uart_frame_sched.sv
// Round-robin frame scheduler feeding one UART tx with paced bytes.
// Optional trailing XOR checksum byte when UART_SCHED_CSUM_EN is defined.
module uart_frame_sched
  import uart_sched_pkg::*;
#(
  parameter int N_SRC       = 2,
  parameter int FRAME_BYTES = 6,
  parameter int GAP_CYCLES  = 52084
) (
  input  logic              clk,
  input  logic              rst,
  uart_frame_sched_if.slave bus
);

  localparam int IW      = $clog2(N_SRC);
  localparam int FRAME_W = FRAME_BYTES * BYTE_W;
  localparam int BI_W    = $clog2(FRAME_BYTES + 1);
  localparam int GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
`ifdef UART_SCHED_CSUM_EN
  localparam int N_XFER  = FRAME_BYTES + 1;
`else
  localparam int N_XFER  = FRAME_BYTES;
`endif

  state_t              state;
  logic [IW-1:0]       rr_ptr;
  logic [IW-1:0]       win_idx;
  logic [N_SRC-1:0]    win_gnt;
  logic [N_SRC-1:0]    arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic [N_SRC-1:0]    grant_q;
  logic [N_SRC-1:0]    done_q;
  logic                busy_q;
  logic [BYTE_W-1:0]   tx_data_q;
  logic                tx_valid_q;
  logic [FRAME_W-1:0]  frame_buf;
  logic [FRAME_W-1:0]  req_frame;
  logic [BI_W-1:0]     byte_idx;
  logic [BI_W-1:0]     next_idx;
  logic [BYTE_W-1:0]   next_byte;
  logic [GAP_W-1:0]    gap_cnt;
  logic                last_byte;

  rr_arbiter #(.N(N_SRC), .IW(IW)) u_arb (
    .req   (bus.req),
    .ptr   (rr_ptr),
    .grant (arb_gnt),
    .index (arb_idx)
  );

  always_comb begin
    req_frame = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (arb_gnt[i]) req_frame = bus.req_data[i*FRAME_W +: FRAME_W];
    end
  end

`ifdef UART_SCHED_CSUM_EN
  logic [BYTE_W-1:0] csum;

  always_comb begin
    csum = '0;
    for (int k = 0; k < FRAME_BYTES; k++) csum = csum ^ frame_buf[k*BYTE_W +: BYTE_W];
  end
`endif

  assign next_idx  = byte_idx + 1'b1;
  assign last_byte = (byte_idx == BI_W'(N_XFER - 1));

  always_comb begin
    next_byte = '0;
    for (int k = 0; k < FRAME_BYTES; k++) begin
      if (next_idx == BI_W'(k)) next_byte = frame_buf[k*BYTE_W +: BYTE_W];
    end
`ifdef UART_SCHED_CSUM_EN
    if (next_idx == BI_W'(FRAME_BYTES)) next_byte = csum;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      win_idx    <= '0;
      win_gnt    <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      frame_buf  <= '0;
      byte_idx   <= '0;
      gap_cnt    <= '0;
    end else begin
      grant_q <= '0;
      done_q  <= '0;
      unique case (state)
        IDLE: begin
          if (|bus.req) begin
            grant_q    <= arb_gnt;
            win_gnt    <= arb_gnt;
            win_idx    <= arb_idx;
            frame_buf  <= req_frame;
            tx_data_q  <= req_frame[BYTE_W-1:0];
            tx_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            byte_idx   <= '0;
            state      <= SEND;
          end
        end
        SEND: begin
          if (tx_valid_q && bus.tx_ready) begin
            if (GAP_CYCLES == 0) begin
              // no pacing: chain straight to the next byte, valid stays high
              if (last_byte) begin
                tx_valid_q <= 1'b0;
                done_q     <= win_gnt;
                state      <= FIN;
              end else begin
                byte_idx  <= next_idx;
                tx_data_q <= next_byte;
              end
            end else begin
              tx_valid_q <= 1'b0;
              gap_cnt    <= GAP_W'(GAP_CYCLES);
              state      <= GAP;
            end
          end
        end
        GAP: begin
          gap_cnt <= gap_cnt - 1'b1;
          if (gap_cnt == GAP_W'(1)) begin
            if (last_byte) begin
              done_q <= win_gnt;
              state  <= FIN;
            end else begin
              byte_idx   <= next_idx;
              tx_data_q  <= next_byte;
              tx_valid_q <= 1'b1;
              state      <= SEND;
            end
          end
        end
        FIN: begin
          busy_q <= 1'b0;
          rr_ptr <= (win_idx == IW'(N_SRC - 1)) ? '0 : win_idx + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Directed bench: table of frame requests plus hand-written backpressure/reset/no-gap sequences.
module tb_uart_frame_sched;

`ifdef UART_SCHED_CSUM_EN
  localparam int NX = 7;
`else
  localparam int NX = 6;
`endif

  typedef struct {
    logic [1:0]  req;
    logic [47:0] f0;
    logic [47:0] f1;
    logic [1:0]  exp_grant;
    logic [47:0] exp_bytes;
    logic [7:0]  exp_csum;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic [1:0]  req_drv = '0;
  logic [95:0] data_drv = '0;
  logic        tx_ready_drv = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  uart_frame_sched_if #(.N_SRC(2), .FRAME_BYTES(6)) ifa ();
  uart_frame_sched_if #(.N_SRC(2), .FRAME_BYTES(6)) ifb ();

  uart_frame_sched #(.N_SRC(2), .FRAME_BYTES(6), .GAP_CYCLES(4)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa.slave)
  );
  uart_frame_sched #(.N_SRC(2), .FRAME_BYTES(6), .GAP_CYCLES(0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb.slave)
  );

  assign ifa.req      = sel ? 2'b00 : req_drv;
  assign ifb.req      = sel ? req_drv : 2'b00;
  assign ifa.req_data = data_drv;
  assign ifb.req_data = data_drv;
  assign ifa.tx_ready = tx_ready_drv;
  assign ifb.tx_ready = tx_ready_drv;

  logic [1:0] grant_o, done_o;
  logic       busy_o, tx_valid_o;
  logic [7:0] tx_data_o;
  assign grant_o    = sel ? ifb.grant    : ifa.grant;
  assign done_o     = sel ? ifb.done     : ifa.done;
  assign busy_o     = sel ? ifb.busy     : ifa.busy;
  assign tx_valid_o = sel ? ifb.tx_valid : ifa.tx_valid;
  assign tx_data_o  = sel ? ifb.tx_data  : ifa.tx_data;

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endfunction

  function automatic void fail_timeout(string name);
    n_total++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      check("grant_a_onehot", 64'($onehot0(ifa.grant)), 64'd1);
      check("grant_b_onehot", 64'($onehot0(ifb.grant)), 64'd1);
      check("done_a_onehot",  64'($onehot0(ifa.done)),  64'd1);
    end
  end

  task automatic request_grant(input logic [1:0] r, input logic [47:0] f0, input logic [47:0] f1,
                               input logic [1:0] exp_grant);
    int guard;
    req_drv  = r;
    data_drv = {f1, f0};
    step();
    guard = 0;
    while (grant_o == 2'b00 && guard < 40) begin
      guard++;
      step();
    end
    if (grant_o == 2'b00) begin
      fail_timeout("grant_wait");
      req_drv = '0;
      return;
    end
    check("grant", grant_o, exp_grant);
    check("valid_with_grant", tx_valid_o, 1'b1);
    check("busy_at_grant", busy_o, 1'b1);
    req_drv  = '0;
    data_drv = ~data_drv;
  endtask

  task automatic stream_frame(input logic [47:0] exp_bytes, input logic [7:0] exp_csum,
                              input logic [1:0] exp_done, input int gap, input int stall_byte);
    int   lows;
    int   guard;
    logic [7:0] eb;
    bit   stall_ok;
    lows = 0;
    for (int b = 0; b < NX; b++) begin
      guard = 0;
      while (!tx_valid_o && guard < 40) begin
        lows++;
        guard++;
        step();
      end
      if (!tx_valid_o) begin
        fail_timeout("byte_wait");
        return;
      end
      eb = (b < 6) ? exp_bytes[8*b +: 8] : exp_csum;
      check($sformatf("byte%0d", b), tx_data_o, eb);
      if (b > 0) check("gap_len", lows, gap);
      if (b == stall_byte) begin
        tx_ready_drv = 1'b0;
        stall_ok = 1'b1;
        repeat (10) begin
          step();
          if (!(tx_valid_o && tx_data_o == eb)) stall_ok = 1'b0;
        end
        check("stall_hold", stall_ok, 1'b1);
        tx_ready_drv = 1'b1;
      end
      lows = 0;
      step();
    end
    guard = 0;
    while (done_o == 2'b00 && guard < 40) begin
      lows++;
      guard++;
      step();
    end
    check("done", done_o, exp_done);
    check("tail_gap", lows, gap);
    check("busy_at_done", busy_o, 1'b1);
    step();
    check("busy_after_done", busy_o, 1'b0);
  endtask

  vec_t tbl [6];
  logic [1:0] rr_exp [4];

  initial begin
    int  guard;
    bit  quiet;
    tbl[0] = '{2'b01, 48'h060504030201, 48'h0,            2'b01, 48'h060504030201, 8'h07};
    tbl[1] = '{2'b11, 48'hDEADBEEF0000, 48'hA0A1A2A3A4A5, 2'b10, 48'hA0A1A2A3A4A5, 8'h01};
    tbl[2] = '{2'b10, 48'h0,            48'h112233445566, 2'b10, 48'h112233445566, 8'h77};
    tbl[3] = '{2'b11, 48'hFF00FF00FF00, 48'h777777777777, 2'b01, 48'hFF00FF00FF00, 8'hFF};
    tbl[4] = '{2'b01, 48'h0123456789AB, 48'h0,            2'b01, 48'h0123456789AB, 8'h22};
    tbl[5] = '{2'b10, 48'h000000000101, 48'h000000000080, 2'b10, 48'h000000000080, 8'h80};
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;

    // reset state
    rst = 1'b1;
    repeat (3) step();
    check("rst_grant", ifa.grant, 2'b00);
    check("rst_done", ifa.done, 2'b00);
    check("rst_busy", ifa.busy, 1'b0);
    check("rst_valid", ifa.tx_valid, 1'b0);
    check("rst_data", ifa.tx_data, 8'h00);
    check("rst_b_valid", ifb.tx_valid, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      request_grant(tbl[i].req, tbl[i].f0, tbl[i].f1, tbl[i].exp_grant);
      stream_frame(tbl[i].exp_bytes, tbl[i].exp_csum, tbl[i].exp_grant, 4, -1);
    end

    // held dual request alternates sources
    req_drv  = 2'b11;
    data_drv = {48'h0A0B0C0D0E0F, 48'h101112131415};
    step();
    for (int k = 0; k < 4; k++) begin
      guard = 0;
      while (grant_o == 2'b00 && guard < 100) begin
        guard++;
        step();
      end
      if (grant_o == 2'b00) fail_timeout("rr_wait");
      else check($sformatf("rr_order%0d", k), grant_o, rr_exp[k]);
      if (k == 3) req_drv = 2'b00;
      step();
    end
    guard = 0;
    while (busy_o && guard < 100) begin
      guard++;
      step();
    end
    check("rr_drain", busy_o, 1'b0);
    step();

    // backpressure on byte 2
    request_grant(2'b01, 48'h060504030201, 48'h0, 2'b01);
    stream_frame(48'h060504030201, 8'h07, 2'b01, 4, 2);

    // reset while byte 3 is pending
    request_grant(2'b01, 48'h060504030201, 48'h0, 2'b01);
    guard = 0;
    while (!(tx_valid_o && tx_data_o == 8'h04) && guard < 60) begin
      guard++;
      step();
    end
    if (!(tx_valid_o && tx_data_o == 8'h04)) fail_timeout("byte3_wait");
    tx_ready_drv = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("mid_rst_valid", tx_valid_o, 1'b0);
    check("mid_rst_grant", grant_o, 2'b00);
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_data", tx_data_o, 8'h00);
    rst = 1'b0;
    tx_ready_drv = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      step();
      if (done_o != 2'b00 || tx_valid_o) quiet = 1'b0;
    end
    check("no_done_after_rst", quiet, 1'b1);
    request_grant(2'b11, 48'h060504030201, 48'hA0A1A2A3A4A5, 2'b01);
    stream_frame(48'h060504030201, 8'h07, 2'b01, 4, -1);

    // no-gap build: back-to-back bytes
    sel = 1'b1;
    step();
    request_grant(2'b01, 48'h060504030201, 48'h0, 2'b01);
    stream_frame(48'h060504030201, 8'h07, 2'b01, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
